pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the RISC-V pipeline. It generalises the fixed IF/ID/EX latch into a valid/ready stage with flush, stall and an optional two-entry skid buffer. The same block instantiates for every boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.
- On flush, control fields are forced to zero, so a flushed slot is a true NOP: no regwrite, no memwrite, no branch.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_skid_buf.sv | 89 ++++++++
 rtl/pipe_stage_reg.sv | 87 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: control-field layout, default widths and skid-buffer state encoding shared by the pipeline stages
package pipe_pkg;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_CTRL_W     = 16;
    localparam int CTRL_BRANCH    = 0;
    localparam int CTRL_MEMREAD   = 1;
    localparam int CTRL_MEMTOREG  = 2;
    localparam int CTRL_MEMWRITE  = 3;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_REGWRITE  = 5;
    localparam int CTRL_JUMP      = 6;
    localparam int CTRL_ALUOP_LSB = 7;
    localparam int CTRL_ALUOP_MSB = 8;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} skid_state_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry FIFO holding stage; main entry is presented, skid entry waits behind it
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              full
);
    skid_state_t       state, state_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt, skid_data, skid_data_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;

    // next state and entry contents; vacated entries are zeroed so an invalid slot is a NOP
    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        main_ctrl_nxt = main_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        if (flush) begin
            state_nxt     = EMPTY;
            main_data_nxt = '0;
            main_ctrl_nxt = '0;
            skid_data_nxt = '0;
            skid_ctrl_nxt = '0;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    state_nxt     = ONE;
                    main_data_nxt = in_data;
                    main_ctrl_nxt = in_ctrl;
                end
                ONE: if (push && pop) begin
                    main_data_nxt = in_data;
                    main_ctrl_nxt = in_ctrl;
                end else if (push) begin
                    state_nxt     = TWO;
                    skid_data_nxt = in_data;
                    skid_ctrl_nxt = in_ctrl;
                end else if (pop) begin
                    state_nxt     = EMPTY;
                    main_data_nxt = '0;
                    main_ctrl_nxt = '0;
                end
                TWO: if (pop) begin
                    state_nxt     = ONE;
                    main_data_nxt = skid_data;
                    main_ctrl_nxt = skid_ctrl;
                    skid_data_nxt = '0;
                    skid_ctrl_nxt = '0;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // state and entry registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            main_ctrl <= main_ctrl_nxt;
            skid_data <= skid_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
        end
    end

    assign out_valid = state != EMPTY;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign full      = state == TWO;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline boundary register with flush, stall, optional skid buffer and flush-discard counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    input  logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  flush_cnt
);
    logic live, in_fire, out_fire, two, held;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign held     = two | (out_valid & ~out_fire);

    // live keeps in_ready low through reset and raises it on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else live <= 1'b1;
    end

    generate
        if (SKID != 0) begin : g_skid
            logic full;
            pipe_skid_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_buf (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (in_fire),
                .pop       (out_ready),
                .flush     (flush),
                .in_data   (in_data),
                .in_ctrl   (in_ctrl),
                .out_valid (out_valid),
                .out_data  (out_data),
                .out_ctrl  (out_ctrl),
                .full      (full)
            );
            assign in_ready = live & ~stall & ~full;
            assign two      = full;
        end else begin : g_reg
            logic              v;
            logic [DATA_W-1:0] d;
            logic [CTRL_W-1:0] c;
            assign in_ready  = live & ~stall & (~v | out_ready);
            assign out_valid = v;
            assign out_data  = d;
            assign out_ctrl  = c;
            assign two       = 1'b0;
            // single holding register: flush clears, accept loads, drain without refill empties
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= 1'b0;
                    d <= '0;
                    c <= '0;
                end else if (flush || (out_fire && !in_fire)) begin
                    v <= 1'b0;
                    d <= '0;
                    c <= '0;
                end else if (in_fire) begin
                    v <= 1'b1;
                    d <= in_data;
                    c <= in_ctrl;
                end
            end
        end
    endgenerate

    // count flushes that actually discarded a held entry, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flush_cnt <= '0;
        else if (flush && held && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
endmodule
